// File: rtl/instruction_sequencer.sv
// Instruction sequencer: IR + 4-phase step counter, one-entry pending buffer; ir valid 1 cycle after accept, done 4 cycles after.
// Backpressure: ready drops while the pending slot is full; hold stalls ir/cont but pending still accepts.
module instruction_sequencer #(
    parameter int IW    = 9,
    parameter int RET_W = 16
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic             run,
    input  logic [IW-1:0]    din,
    output logic             ready,
    input  logic             hold,
    output logic [IW-1:0]    ir,
    output logic [1:0]       cont,
    output logic             busy,
    output logic             done,
    output logic [RET_W-1:0] retired
);

    typedef enum logic {S_IDLE, S_EXEC} state_t;

    state_t            state_q, state_d;
    logic [IW-1:0]     ir_q, ir_d;
    logic [1:0]        cont_q, cont_d;
    logic [IW-1:0]     pend_q, pend_d;
    logic              pend_vld_q, pend_vld_d;
    logic [RET_W-1:0]  retired_q, retired_d;
    logic              xfer;
    logic              last_phase;

    assign xfer       = run & ~pend_vld_q;
    assign last_phase = (state_q == S_EXEC) & (cont_q == 2'b11) & ~hold;

    always_ff @(posedge clock) begin
        if (resetn) begin
            state_q    <= S_IDLE;
            ir_q       <= '0;
            cont_q     <= 2'b00;
            pend_q     <= '0;
            pend_vld_q <= 1'b0;
            retired_q  <= '0;
        end else begin
            state_q    <= state_d;
            ir_q       <= ir_d;
            cont_q     <= cont_d;
            pend_q     <= pend_d;
            pend_vld_q <= pend_vld_d;
            retired_q  <= retired_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        ir_d       = ir_q;
        cont_d     = cont_q;
        pend_d     = pend_q;
        pend_vld_d = pend_vld_q;
        retired_d  = retired_q;
        case (state_q)
            S_IDLE: begin
                if (xfer) begin
                    ir_d    = din;
                    cont_d  = 2'b00;
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                if (!hold) begin
                    if (cont_q != 2'b11) begin
                        cont_d = cont_q + 2'b01;
                    end else begin
                        cont_d    = 2'b00;
                        retired_d = retired_q + 1'b1;
                        if (pend_vld_q) begin
                            ir_d       = pend_q;
                            pend_vld_d = 1'b0;
                        end else if (xfer) begin
                            ir_d = din;
                        end else begin
                            state_d = S_IDLE;
                        end
                    end
                end
                // A word arriving on the retiring edge bypasses straight into ir instead.
                if (xfer && !last_phase) begin
                    pend_d     = din;
                    pend_vld_d = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        ready   = ~pend_vld_q;
        busy    = (state_q == S_EXEC);
        done    = last_phase;
        ir      = ir_q;
        cont    = cont_q;
        retired = retired_q;
    end

endmodule

// File: tb/tb_instruction_sequencer.sv
// Randomized + directed bench for instruction_sequencer against a queue-based reference model.
module tb_instruction_sequencer;

    localparam int IW = 9;

    logic          clock = 1'b0;
    logic          resetn, run, hold;
    logic [IW-1:0] din;
    logic          ready, busy, done;
    logic [IW-1:0] ir;
    logic [1:0]    cont;
    logic [15:0]   retired;
    logic          ready2, busy2, done2;
    logic [IW-1:0] ir2;
    logic [1:0]    cont2;
    logic [1:0]    retired2;

    int n_pass = 0;
    int n_total = 0;

    // Reference model: words accepted but not yet started wait in a queue.
    logic [IW-1:0] q_m[$];
    logic [IW-1:0] ir_m;
    int            phase_m;
    bit            busy_m;
    int            retired_m;

    always #5 clock = ~clock;

    instruction_sequencer #(.IW(IW), .RET_W(16)) dut (
        .clock(clock), .resetn(resetn), .run(run), .din(din), .ready(ready),
        .hold(hold), .ir(ir), .cont(cont), .busy(busy), .done(done), .retired(retired)
    );

    instruction_sequencer #(.IW(IW), .RET_W(2)) dut2 (
        .clock(clock), .resetn(resetn), .run(run), .din(din), .ready(ready2),
        .hold(hold), .ir(ir2), .cont(cont2), .busy(busy2), .done(done2), .retired(retired2)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    endtask

    task automatic model_step();
        if (resetn) begin
            q_m.delete();
            ir_m = '0; phase_m = 0; busy_m = 0; retired_m = 0;
            return;
        end
        if (run && q_m.size() == 0) q_m.push_back(din);
        if (!busy_m) begin
            if (q_m.size() > 0) begin
                ir_m = q_m.pop_front(); phase_m = 0; busy_m = 1;
            end
        end else if (!hold) begin
            if (phase_m < 3) begin
                phase_m++;
            end else begin
                retired_m++;
                phase_m = 0;
                if (q_m.size() > 0) ir_m = q_m.pop_front();
                else busy_m = 0;
            end
        end
    endtask

    task automatic check_all();
        bit done_m;
        done_m = busy_m && phase_m == 3 && !hold;
        chk("ready",    32'(ready),    32'(q_m.size() == 0));
        chk("busy",     32'(busy),     32'(busy_m));
        chk("cont",     32'(cont),     32'(phase_m));
        chk("ir",       32'(ir),       32'(ir_m));
        chk("done",     32'(done),     32'(done_m));
        chk("retired",  32'(retired),  32'(retired_m % 65536));
        chk("retired2", 32'(retired2), 32'(retired_m % 4));
        chk("done2",    32'(done2),    32'(done_m));
    endtask

    // Inputs are applied at the falling edge; the model advances with the rising edge.
    task automatic drive(input bit r, input logic [IW-1:0] d, input bit h, input bit rst, input int n);
        for (int i = 0; i < n; i++) begin
            run = r; din = d; hold = h; resetn = rst;
            @(posedge clock);
            model_step();
            @(negedge clock);
            check_all();
        end
    endtask

    initial begin
        resetn = 1'b1; run = 1'b0; hold = 1'b0; din = '0;
        q_m.delete(); ir_m = '0; phase_m = 0; busy_m = 0; retired_m = 0;
        @(negedge clock);

        drive(1, 9'h1FF, 0, 1, 2);
        chk("rst_ir", 32'(ir), 32'h0);
        chk("rst_ready", 32'(ready), 32'h1);

        drive(1, 9'b000_001_010, 0, 0, 1);
        drive(0, 9'h0, 0, 0, 4);
        chk("single_ir", 32'(ir), 32'h00A);
        chk("single_ret", 32'(retired), 32'h1);

        drive(1, 9'h0A5, 0, 0, 1);
        drive(1, 9'h13C, 0, 0, 4);
        drive(0, 9'h0, 0, 0, 5);
        chk("b2b_ret", 32'(retired), 32'h3);

        drive(1, 9'h033, 0, 0, 1);
        drive(0, 9'h0, 0, 0, 3);
        drive(1, 9'h140, 0, 0, 1);
        chk("byp_ir", 32'(ir), 32'h140);
        chk("byp_ready", 32'(ready), 32'h1);
        drive(0, 9'h0, 0, 0, 4);

        drive(1, 9'h0F0, 0, 0, 1);
        drive(0, 9'h0, 0, 0, 2);
        drive(0, 9'h0, 1, 0, 3);
        chk("stall_cont", 32'(cont), 32'h2);
        drive(0, 9'h0, 0, 0, 3);

        drive(1, 9'h055, 0, 0, 1);
        drive(1, 9'h1AA, 0, 0, 1);
        chk("mid_ready", 32'(ready), 32'h0);
        drive(0, 9'h0, 0, 1, 1);
        chk("mid_busy", 32'(busy), 32'h0);

        for (int k = 0; k < 5; k++) begin
            drive(1, 9'(k + 1), 0, 0, 1);
            drive(0, 9'h0, 0, 0, 4);
        end
        chk("wrap2", 32'(retired2), 32'h1);

        drive(1, 9'h077, 0, 0, 30);

        for (int i = 0; i < 2000; i++) begin
            drive(($urandom % 3) != 0, 9'($urandom), ($urandom % 4) == 0,
                  ($urandom % 150) == 0, 1);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
